// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared encodings, states and size helpers for the PE memory unit
package pe_pkg;

    localparam logic [3:0] F_LB  = 4'b0000;
    localparam logic [3:0] F_LH  = 4'b0001;
    localparam logic [3:0] F_LW  = 4'b0010;
    localparam logic [3:0] F_LD  = 4'b0011;
    localparam logic [3:0] F_LBU = 4'b0100;
    localparam logic [3:0] F_LHU = 4'b0101;
    localparam logic [3:0] F_LWU = 4'b0110;
    localparam logic [3:0] F_SB  = 4'b1000;
    localparam logic [3:0] F_SH  = 4'b1001;
    localparam logic [3:0] F_SW  = 4'b1010;
    localparam logic [3:0] F_SD  = 4'b1011;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } err_t;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;

    function automatic size_t funct_size(input logic [3:0] f);
        return size_t'(f[1:0]);
    endfunction

    // 64-bit accesses and lwu only exist on a 64-bit data path
    function automatic logic funct_legal(input logic [3:0] f, input int data_w);
        logic ok;
        case (f)
            F_LB, F_LH, F_LW, F_LBU, F_LHU, F_SB, F_SH, F_SW: ok = 1'b1;
            F_LD, F_LWU, F_SD:                               ok = (data_w == 64);
            default:                                         ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] ea_lo, input size_t sz);
        logic bad;
        case (sz)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = ea_lo[0];
            SZ_W:    bad = |ea_lo[1:0];
            default: bad = |ea_lo;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/pe_mem_align.sv
// rtl/pe_mem_align.sv - byte-lane placement for stores and lane extraction/extension for loads
module pe_mem_align
    import pe_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int BE_W   = DATA_W / 8,
    localparam int LANE_W = $clog2(BE_W)
) (
    input  logic [LANE_W-1:0] st_lane,
    input  size_t             st_size,
    input  logic [DATA_W-1:0] st_data,
    output logic [BE_W-1:0]   st_be,
    output logic [DATA_W-1:0] st_wdata,
    input  logic [LANE_W-1:0] ld_lane,
    input  size_t             ld_size,
    input  logic              ld_unsigned,
    input  logic [DATA_W-1:0] ld_rdata,
    output logic [DATA_W-1:0] ld_data
);

    logic [BE_W-1:0]   base_be;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic              sign;

    always_comb begin
        base_be = '0;
        case (st_size)
            SZ_B:    base_be = BE_W'(8'h01);
            SZ_H:    base_be = BE_W'(8'h03);
            SZ_W:    base_be = BE_W'(8'h0F);
            default: base_be = BE_W'(8'hFF);
        endcase
        st_be    = base_be << st_lane;
        st_wdata = st_data << {st_lane, 3'b000};
    end

    // Bring the addressed lanes down to bit 0, then fill above the access size
    always_comb begin
        shifted = ld_rdata >> {ld_lane, 3'b000};
        mask    = '1;
        sign    = shifted[DATA_W-1];
        case (ld_size)
            SZ_B: begin
                mask = DATA_W'(64'hFF);
                sign = shifted[7];
            end
            SZ_H: begin
                mask = DATA_W'(64'hFFFF);
                sign = shifted[15];
            end
            SZ_W: begin
                mask = DATA_W'(64'hFFFF_FFFF);
                sign = shifted[31];
            end
            default: begin
                mask = '1;
                sign = shifted[DATA_W-1];
            end
        endcase
        ld_data = shifted & mask;
        if (!ld_unsigned && sign) begin
            ld_data = ld_data | ~mask;
        end
    end

endmodule

// File: rtl/pe_mem_unit.sv
// rtl/pe_mem_unit.sv - PE load/store unit: EA formation, memory handshake, load alignment, result token
module pe_mem_unit
    import pe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          funct,
    input  logic [DATA_W-1:0]   opA,
    input  logic [DATA_W-1:0]   opB,
    input  logic [9:0]          offset,
    input  logic [DATA_W-1:0]   st_data,
    input  logic [5:0]          ta1,
    input  logic [5:0]          ta2,
    input  logic [1:0]          tt1,
    input  logic [1:0]          tt2,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_Message,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [DATA_W-1:0]   res_data,
    output logic [5:0]          res_ta1,
    output logic [5:0]          res_ta2,
    output logic [1:0]          res_tt1,
    output logic [1:0]          res_tt2,
    output logic                res_store,
    output logic [1:0]          res_err
);

    localparam int BE_W   = DATA_W / 8;
    localparam int LANE_W = $clog2(BE_W);
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    size_t             size_q;
    logic              unsigned_q;
    logic              store_q;
    logic [LANE_W-1:0] lane_q;

    logic [ADDR_W-1:0] off_x;
    logic [ADDR_W-1:0] ea;
    size_t             in_size;
    logic              in_legal;
    logic              in_misalign;
    logic [BE_W-1:0]   st_be;
    logic [DATA_W-1:0] st_wdata;
    logic [DATA_W-1:0] ld_data;

    always_comb begin
        off_x       = ADDR_W'($signed(offset));
        ea          = ADDR_W'(opA) + ADDR_W'(opB) + off_x;
        in_size     = funct_size(funct);
        in_legal    = funct_legal(funct, DATA_W);
        in_misalign = misaligned(ea[2:0], in_size);
    end

    // Store lanes come from the live instruction; load lanes from the captured access
    pe_mem_align #(.DATA_W(DATA_W)) u_align (
        .st_lane     (ea[LANE_W-1:0]),
        .st_size     (in_size),
        .st_data     (st_data),
        .st_be       (st_be),
        .st_wdata    (st_wdata),
        .ld_lane     (lane_q),
        .ld_size     (size_q),
        .ld_unsigned (unsigned_q),
        .ld_rdata    (mem_Message),
        .ld_data     (ld_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            size_q      <= SZ_B;
            unsigned_q  <= 1'b0;
            store_q     <= 1'b0;
            lane_q      <= '0;
            in_ready    <= 1'b1;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_ta1     <= '0;
            res_ta2     <= '0;
            res_tt1     <= '0;
            res_tt2     <= '0;
            res_store   <= 1'b0;
            res_err     <= ERR_OK;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready   <= 1'b0;
                        size_q     <= in_size;
                        unsigned_q <= funct[2];
                        store_q    <= funct[3];
                        lane_q     <= ea[LANE_W-1:0];
                        res_ta1    <= ta1;
                        res_ta2    <= ta2;
                        res_tt1    <= tt1;
                        res_tt2    <= tt2;
                        res_data   <= '0;
                        res_store  <= 1'b0;
                        cnt        <= '0;
                        if (!in_legal || in_misalign) begin
                            res_err   <= in_legal ? ERR_MISALIGN : ERR_ILLEGAL;
                            res_valid <= 1'b1;
                            state     <= S_RESP;
                        end else begin
                            res_err     <= ERR_OK;
                            mem_read    <= ~funct[3];
                            mem_write   <= funct[3];
                            mem_address <= {ea[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                            mem_be      <= st_be;
                            mem_wdata   <= funct[3] ? st_wdata : '0;
                            state       <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        mem_be    <= '0;
                        res_data  <= store_q ? '0 : ld_data;
                        res_store <= store_q;
                        res_valid <= 1'b1;
                        state     <= S_RESP;
                    end else if (TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT - 1)) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        mem_be    <= '0;
                        res_err   <= ERR_TIMEOUT;
                        res_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_mem_unit.sv
// tb/tb_pe_mem_unit.sv - self-checking bench for pe_mem_unit at DATA_W 32 and 64
module tb_pe_mem_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic [3:0]  funct;
    logic [9:0]  offset;
    logic [5:0]  ta1, ta2;
    logic [1:0]  tt1, tt2;

    logic        in_valid, in_ready, mem_read, mem_write, mem_ack, res_valid, res_ready, res_store;
    logic [31:0] opA, opB, st_data, mem_address, mem_wdata, mem_Message, res_data;
    logic [3:0]  mem_be;
    logic [5:0]  res_ta1, res_ta2;
    logic [1:0]  res_tt1, res_tt2, res_err;

    logic        w_in_valid, w_in_ready, w_mem_read, w_mem_write, w_mem_ack, w_res_valid, w_res_ready, w_res_store;
    logic [63:0] w_opA, w_opB, w_st_data, w_mem_wdata, w_mem_Message, w_res_data;
    logic [31:0] w_mem_address;
    logic [7:0]  w_mem_be;
    logic [5:0]  w_res_ta1, w_res_ta2;
    logic [1:0]  w_res_tt1, w_res_tt2, w_res_err;

    pe_mem_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .funct(funct),
        .opA(opA), .opB(opB), .offset(offset), .st_data(st_data),
        .ta1(ta1), .ta2(ta2), .tt1(tt1), .tt2(tt2),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_Message(mem_Message),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_ta1(res_ta1), .res_ta2(res_ta2), .res_tt1(res_tt1), .res_tt2(res_tt2),
        .res_store(res_store), .res_err(res_err)
    );

    pe_mem_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(8)) u_dut64 (
        .clk(clk), .reset_n(reset_n), .in_valid(w_in_valid), .in_ready(w_in_ready), .funct(funct),
        .opA(w_opA), .opB(w_opB), .offset(offset), .st_data(w_st_data),
        .ta1(ta1), .ta2(ta2), .tt1(tt1), .tt2(tt2),
        .mem_read(w_mem_read), .mem_write(w_mem_write), .mem_address(w_mem_address), .mem_wdata(w_mem_wdata),
        .mem_be(w_mem_be), .mem_ack(w_mem_ack), .mem_Message(w_mem_Message),
        .res_valid(w_res_valid), .res_ready(w_res_ready), .res_data(w_res_data),
        .res_ta1(w_res_ta1), .res_ta2(w_res_ta2), .res_tt1(w_res_tt1), .res_tt2(w_res_tt2),
        .res_store(w_res_store), .res_err(w_res_err)
    );

    typedef struct {
        logic [3:0]  funct;
        logic [31:0] opA, opB;
        logic [9:0]  offset;
        logic [31:0] st_data, rdata;
        int          delay;
        int          kind;     // 0 error, 1 read, 2 write
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata, data;
        logic [1:0]  err;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic [5:0]  ta1, ta2;
        logic [1:0]  tt1, tt2;
        logic        store;
        logic [1:0]  err;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input logic [9:0] off, input logic [31:0] sd, input logic [31:0] rd,
                                 input int dly, input int kind, input logic [31:0] addr, input logic [3:0] be,
                                 input logic [31:0] wd, input logic [31:0] data, input logic [1:0] err);
        vec_t v;
        v.funct = f; v.opA = a; v.opB = b; v.offset = off; v.st_data = sd; v.rdata = rd;
        v.delay = dly; v.kind = kind; v.addr = addr; v.be = be; v.wdata = wd; v.data = data; v.err = err;
        return v;
    endfunction

    task automatic drive_tags(input int idx);
        ta1 = 6'(idx + 1);
        ta2 = 6'(62 - idx);
        tt1 = 2'(idx);
        tt2 = 2'(idx + 2);
    endtask

    function automatic exp_t mk_exp(input int idx, input logic [63:0] data, input logic store, input logic [1:0] err);
        exp_t e;
        e.data = data; e.store = store; e.err = err;
        e.ta1 = 6'(idx + 1); e.ta2 = 6'(62 - idx); e.tt1 = 2'(idx); e.tt2 = 2'(idx + 2);
        return e;
    endfunction

    task automatic check_result32(input string tag);
        exp_t e;
        check({tag, "_res_valid"}, res_valid, 1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({tag, "_data"}, res_data, e.data);
            check({tag, "_store"}, res_store, e.store);
            check({tag, "_err"}, res_err, e.err);
            check({tag, "_tags"}, {res_ta1, res_ta2, res_tt1, res_tt2}, {e.ta1, e.ta2, e.tt1, e.tt2});
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_valid_drop"}, res_valid, 0);
        check({tag, "_in_ready_back"}, in_ready, 1);
    endtask

    task automatic run32(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v32_%0d", idx);
        @(negedge clk);
        check({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1; funct = v.funct; opA = v.opA; opB = v.opB; offset = v.offset; st_data = v.st_data;
        drive_tags(idx);
        sb.push_back(mk_exp(idx, 64'(v.data), v.kind == 2, v.err));
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_in_ready_busy"}, in_ready, 0);
        if (v.kind == 0) begin
            check({tag, "_no_strobe"}, {mem_read, mem_write}, 2'b00);
        end else begin
            for (int c = 0; c <= v.delay; c++) begin
                check({tag, "_strobe"}, {mem_read, mem_write}, (v.kind == 1) ? 2'b10 : 2'b01);
                check({tag, "_addr"}, mem_address, v.addr);
                check({tag, "_be"}, mem_be, v.be);
                if (v.kind == 2) check({tag, "_wdata"}, mem_wdata, v.wdata);
                check({tag, "_early_valid"}, res_valid, 0);
                if (c == v.delay) begin
                    mem_ack = 1'b1;
                    mem_Message = v.rdata;
                end
                @(negedge clk);
            end
            mem_ack = 1'b0;
            mem_Message = 32'h0BAD_F00D;
            check({tag, "_strobe_drop"}, {mem_read, mem_write}, 2'b00);
        end
        check_result32(tag);
    endtask

    task automatic run64(input logic [3:0] f, input logic [31:0] ea, input logic [63:0] rdata,
                         input logic [7:0] be, input logic [63:0] data, input int idx);
        exp_t  e;
        string tag;
        tag = $sformatf("v64_%0d", idx);
        @(negedge clk);
        check({tag, "_in_ready"}, w_in_ready, 1);
        w_in_valid = 1'b1; funct = f; w_opA = 64'(ea); w_opB = '0; offset = '0;
        drive_tags(idx);
        sb.push_back(mk_exp(idx, data, 1'b0, 2'b00));
        @(negedge clk);
        w_in_valid = 1'b0;
        check({tag, "_read"}, {w_mem_read, w_mem_write}, 2'b10);
        check({tag, "_addr"}, w_mem_address, ea & ~32'h7);
        check({tag, "_be"}, w_mem_be, be);
        w_mem_ack = 1'b1;
        w_mem_Message = rdata;
        @(negedge clk);
        w_mem_ack = 1'b0;
        check({tag, "_res_valid"}, w_res_valid, 1);
        e = sb.pop_front();
        check({tag, "_data"}, w_res_data, e.data);
        check({tag, "_err"}, w_res_err, e.err);
        check({tag, "_tags"}, {w_res_ta1, w_res_ta2, w_res_tt1, w_res_tt2}, {e.ta1, e.ta2, e.tt1, e.tt2});
        w_res_ready = 1'b1;
        @(negedge clk);
        w_res_ready = 1'b0;
        check({tag, "_in_ready_back"}, w_in_ready, 1);
    endtask

    initial begin
        reset_n = 1'b0;
        in_valid = 0; funct = 0; opA = 0; opB = 0; offset = 0; st_data = 0; mem_ack = 0; mem_Message = 0; res_ready = 0;
        w_in_valid = 0; w_opA = 0; w_opB = 0; w_st_data = 0; w_mem_ack = 0; w_mem_Message = 0; w_res_ready = 0;
        ta1 = 0; ta2 = 0; tt1 = 0; tt2 = 0;

        tbl.push_back(mkv(4'b0100, 32'd4, 32'd66, 10'd0, 0, 32'hAAAA_AAAA, 2, 1, 32'h44, 4'b0100, 0, 32'h0000_00AA, 2'b00));
        tbl.push_back(mkv(4'b0001, 32'h10, 0, 10'd2, 0, 32'h8001_0000, 0, 1, 32'h10, 4'b1100, 0, 32'hFFFF_8001, 2'b00));
        tbl.push_back(mkv(4'b1000, 32'h100, 0, 10'd3, 32'h1234_565A, 0, 1, 2, 32'h100, 4'b1000, 32'h5A00_0000, 0, 2'b00));
        tbl.push_back(mkv(4'b0010, 0, 32'h10, 10'h3F6, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01));
        tbl.push_back(mkv(4'b0011, 32'h8, 0, 10'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11));
        tbl.push_back(mkv(4'b0000, 32'h11, 0, 10'h3F0, 0, 32'h0000_8000, 0, 1, 32'h0, 4'b0010, 0, 32'hFFFF_FF80, 2'b00));
        tbl.push_back(mkv(4'b0101, 32'h20, 32'd2, 10'd0, 0, 32'hFEDC_0000, 1, 1, 32'h20, 4'b1100, 0, 32'h0000_FEDC, 2'b00));
        tbl.push_back(mkv(4'b1010, 32'h40, 0, 10'd0, 32'hDEAD_BEEF, 0, 0, 2, 32'h40, 4'b1111, 32'hDEAD_BEEF, 0, 2'b00));
        tbl.push_back(mkv(4'b1001, 32'h42, 0, 10'd0, 32'h0000_BEEF, 0, 2, 2, 32'h40, 4'b1100, 32'hBEEF_0000, 0, 2'b00));
        tbl.push_back(mkv(4'b0110, 0, 0, 10'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11));
        tbl.push_back(mkv(4'b0111, 0, 0, 10'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11));
        tbl.push_back(mkv(4'b1100, 0, 0, 10'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11));
        tbl.push_back(mkv(4'b1001, 32'h43, 0, 10'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01));
        tbl.push_back(mkv(4'b0010, 32'hFFFF_FFFC, 0, 10'd8, 0, 32'h1357_9BDF, 3, 1, 32'h4, 4'b1111, 0, 32'h1357_9BDF, 2'b00));

        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_strobes", {mem_read, mem_write, w_mem_read, w_mem_write}, 0);
        check("rst_res_valid", {res_valid, w_res_valid}, 0);
        check("rst_res_err", {res_err, w_res_err}, 0);
        check("rst_res_data", res_data, 0);
        check("rst_be", mem_be, 0);

        for (int i = 0; i < tbl.size(); i++) run32(tbl[i], i);

        // Timeout: no ack for 4 REQ cycles, then a late ack must be ignored
        @(negedge clk);
        in_valid = 1'b1; funct = 4'b0010; opA = 32'h80; opB = 0; offset = 0;
        drive_tags(20);
        sb.push_back(mk_exp(20, 64'h0, 1'b0, 2'b10));
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("tmo_strobe_%0d", c), mem_read, 1);
            check($sformatf("tmo_no_valid_%0d", c), res_valid, 0);
            @(negedge clk);
        end
        check("tmo_strobe_drop", mem_read, 0);
        mem_ack = 1'b1; mem_Message = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        check_result32("tmo");
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("idle_ack_ignored", {mem_read, res_valid}, 2'b00);
        run32(tbl[0], 30);

        // res_ready held high on the error path
        res_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; funct = 4'b0010; opA = 32'h6; opB = 0; offset = 0;
        @(negedge clk);
        in_valid = 1'b0;
        check("hold_valid", res_valid, 1);
        check("hold_err", res_err, 2'b01);
        check("hold_in_ready_low", in_ready, 0);
        @(negedge clk);
        check("hold_valid_drop", res_valid, 0);
        check("hold_in_ready", in_ready, 1);
        res_ready = 1'b0;

        run64(4'b0110, 32'h4, 64'hF000_0001_1234_5678, 8'hF0, 64'h0000_0000_F000_0001, 40);
        run64(4'b0011, 32'h8, 64'h8000_0000_0000_0001, 8'hFF, 64'h8000_0000_0000_0001, 41);
        run64(4'b0000, 32'hF, 64'h7F00_0000_0000_0000, 8'h80, 64'h0000_0000_0000_007F, 42);
        run64(4'b0010, 32'h4, 64'h8000_0000_0000_0000, 8'hF0, 64'hFFFF_FFFF_8000_0000, 43);

        // Reset pulsed while a 64-bit read is outstanding
        @(negedge clk);
        w_in_valid = 1'b1; funct = 4'b0010; w_opA = 64'h10; w_opB = 0; offset = 0;
        @(negedge clk);
        w_in_valid = 1'b0;
        check("rreq_strobe", w_mem_read, 1);
        #2 reset_n = 1'b0;
        #1;
        check("rreq_strobe_async_drop", {w_mem_read, w_mem_write}, 2'b00);
        check("rreq_be_clear", w_mem_be, 0);
        @(negedge clk);
        reset_n = 1'b1;
        w_mem_ack = 1'b1;
        @(negedge clk);
        w_mem_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("rreq_no_result_%0d", c), w_res_valid, 0);
            @(negedge clk);
        end
        check("rreq_in_ready", w_in_ready, 1);
        check("rreq_no_strobe", w_mem_read, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_mem_unit.md
# pe_mem_unit

Parametrised load/store unit for the Pasithea PE, taking over memory-class instructions (op = 001) from the controller. Accepts one decoded memory instruction per handshake, forms the effective address, runs the mem_read/mem_write/mem_ack transaction, aligns and extends load data, and returns a result token with its destination fields (ta1/tt1, ta2/tt2). Adds generic data width, byte enables, stores, misalignment detection and an ack timeout.

## Interface
- DATA_W, 32: data path width, 32 or 64
- ADDR_W, 32: memory address width
- TIMEOUT, 255: max cycles waiting for mem_ack before error; 0 disables timeout
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid / in_ready  in / out  1  instruction handshake
- funct  in  4  access type: 0000 lb, 0001 lh, 0010 lw, 0011 ld, 0100 lbu, 0101 lhu, 0110 lwu, 1000 sb, 1001 sh, 1010 sw, 1011 sd
- opA, opB  in  DATA_W  address operands
- offset  in  10  signed address offset
- st_data  in  DATA_W  store data, low bytes used
- ta1, ta2  in  6 each; tt1, tt2  in  2 each  result destinations, carried through
- mem_read, mem_write  out  1  request strobes
- mem_address  out  ADDR_W  byte address of the access
- mem_wdata  out  DATA_W  lane-shifted store data
- mem_be  out  DATA_W/8  byte enables
- mem_ack  in  1  one-cycle completion
- mem_Message  in  DATA_W  read data, valid on mem_ack
- res_valid / res_ready  out / in  1  result handshake
- res_data  out  DATA_W  load result (0 for stores and errors)
- res_ta1, res_ta2  out  6; res_tt1, res_tt2  out  2  captured destinations
- res_store  out  1  result is a store completion (no data write-back)
- res_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct

## Operation
- States IDLE, REQ, RESP. in_ready = 1 only in IDLE.
- IDLE: on in_valid & in_ready capture all inputs; EA = (opA + opB + sext(offset)) truncated to ADDR_W, mod 2^ADDR_W.
- Size: byte/half/word/dword from funct[1:0]; dword and lwu illegal when DATA_W = 32; unlisted codes illegal.
- Alignment: EA must be multiple of size; otherwise misaligned.
- Illegal or misaligned: no memory strobe; go straight to RESP with res_err set, res_data 0.
- Otherwise go to REQ: assert mem_read (load) or mem_write (store) with mem_address = EA aligned down to DATA_W/8 bytes, mem_be = size mask shifted by EA low bits, mem_wdata = st_data shifted to the same lanes. Held stable until mem_ack.
- Load on mem_ack: extract lanes at EA offset, sign-extend (lb, lh, lw, ld) or zero-extend (lbu, lhu, lwu) to DATA_W; go RESP.
- Store on mem_ack: res_store = 1, res_data = 0; go RESP.
- Timeout counter runs in REQ; reaching TIMEOUT cycles without ack drops strobes, res_err = 10, go RESP. A late mem_ack arriving after that is ignored.
- RESP: res_valid = 1, outputs stable until res_ready; on res_valid & res_ready return to IDLE.

## Timing
- Reset: state IDLE, in_ready 1 after release, all other outputs 0 including mem_read, mem_write, res_valid, res_err.
- Reset asserted mid-transaction aborts immediately; strobes drop asynchronously; no result emitted.
- Latency: accept edge N, strobe visible cycle N+1; ack in cycle M -> res_valid from cycle M+1. Error path: res_valid cycle N+1.
- Minimum throughput one instruction per 3 cycles (IDLE, REQ, RESP); zero-wait ack in the first REQ cycle allowed.
- mem_ack outside REQ ignored. res_ready held high is legal; in_ready rises the cycle after the result handshake.

## Structure
- Shared package pe_pkg: funct encodings, res_err codes, state enum, size helpers.
- Optional sub-module pe_mem_align: combinational lane shift, byte-enable generation and load extraction/extension, parametrised by DATA_W.

## Test plan
- DATA_W=32, lbu, opA=4, opB=66, offset=0, mem_Message=0xAAAAAAAA, ack after 2 cycles -> mem_address=0x44, mem_be=0b0100, res_data=0x000000AA, res_err=00, ta/tt echoed.
- lh at EA=0x12, mem_Message=0x8001_0000 -> mem_be=0b1100, res_data=0xFFFF8001.
- sb st_data=0x5A at EA=0x103 -> mem_write, mem_address=0x100, mem_be=0b1000, mem_wdata=0x5A000000, res_store=1.
- lw at EA=0x6 -> no strobe, res_valid next cycle, res_err=01; ld with DATA_W=32 -> res_err=11.
- TIMEOUT=4, no ack -> strobe for 4 cycles then res_err=10; later mem_ack ignored, next instruction accepted normally.
- DATA_W=64: lwu at EA=0x4, mem_Message=0xF000_0001_xxxx_xxxx -> res_data=0x00000000F0000001; reset_n pulsed in REQ -> strobes 0 at once, no res_valid.
